// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants and types used by the frame splitter and the
// ARP receive path.
package eth_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH   = 16'h0001;
  localparam logic [15:0] IP_TYPE         = 16'h0800;
  localparam logic [7:0]  ARP_HLEN        = 8'd6;
  localparam logic [7:0]  ARP_PLEN        = 8'd4;
  localparam logic [15:0] ARP_OPER_REQ    = 16'd1;
  localparam logic [15:0] ARP_OPER_REP    = 16'd2;
  localparam logic [7:0]  ARP_BODY_LENGTH = 8'd28;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    DRAIN,
    CHECK,
    OUT
  } state_arp_rx;

  typedef struct packed {
    logic [15:0] oper;
    logic [47:0] smac;
    logic [31:0] sip;
  } arp_info_t;

endpackage

// File: rtl/arp_rx_parse_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/arp_rx_parse.sv
// ARP body parser: captures the 28-byte ARP body, drops padding, validates
// fixed fields and target IP, and emits one record per accepted frame.
module arp_rx_parse
  import eth_pkg::*;
#(
  parameter logic [31:0] LOCAL_IP  = 32'hC0A8_006E,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 logic_clk,
  input  logic                 logic_rst_n,
  input  logic [7:0]           arp_rdata_in,
  input  logic                 arp_rvalid_in,
  output logic                 arp_rready_out,
  input  logic                 arp_rlast_in,
  output logic                 arp_info_valid_out,
  input  logic                 arp_info_ready_in,
  output logic [15:0]          arp_info_oper_out,
  output logic [47:0]          arp_info_smac_out,
  output logic [31:0]          arp_info_sip_out,
  output logic [CNT_WIDTH-1:0] arp_ok_cnt_out,
  output logic [CNT_WIDTH-1:0] arp_drop_cnt_out
);

  localparam logic [4:0] LAST_IDX = 5'(ARP_BODY_LENGTH - 8'd1);
  localparam logic [4:0] CNT_SAT  = 5'(ARP_BODY_LENGTH);

  state_arp_rx state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] htype_q, htype_d;
  logic [15:0] ptype_q, ptype_d;
  logic [7:0]  hlen_q, hlen_d;
  logic [7:0]  plen_q, plen_d;
  logic [15:0] oper_q, oper_d;
  logic [47:0] sha_q, sha_d;
  logic [31:0] spa_q, spa_d;
  logic [31:0] tpa_q, tpa_d;
  arp_info_t   info_q, info_d;

  logic       rready;
  logic       hs;
  logic [4:0] cap_idx;
  logic       pass;
  logic       ok_inc;
  logic       drop_inc;

  assign rready  = (state_q == IDLE) || (state_q == RECV) || (state_q == DRAIN);
  assign hs      = arp_rvalid_in && rready;
  assign cap_idx = (state_q == IDLE) ? 5'd0 : cnt_q;

  assign pass = (htype_q == ARP_HTYPE_ETH) && (ptype_q == IP_TYPE) &&
                (hlen_q == ARP_HLEN) && (plen_q == ARP_PLEN) &&
                ((oper_q == ARP_OPER_REQ) || (oper_q == ARP_OPER_REP)) &&
                (tpa_q == LOCAL_IP);

  // Field capture: every field is big-endian, so shifting bytes in from the
  // LSB leaves the first byte in the MSB once the field is complete.
  always_comb begin
    htype_d = htype_q;
    ptype_d = ptype_q;
    hlen_d  = hlen_q;
    plen_d  = plen_q;
    oper_d  = oper_q;
    sha_d   = sha_q;
    spa_d   = spa_q;
    tpa_d   = tpa_q;
    if (hs && ((state_q == IDLE) || (state_q == RECV))) begin
      if (cap_idx <= 5'd1) begin
        htype_d = {htype_q[7:0], arp_rdata_in};
      end else if (cap_idx <= 5'd3) begin
        ptype_d = {ptype_q[7:0], arp_rdata_in};
      end else if (cap_idx == 5'd4) begin
        hlen_d = arp_rdata_in;
      end else if (cap_idx == 5'd5) begin
        plen_d = arp_rdata_in;
      end else if (cap_idx <= 5'd7) begin
        oper_d = {oper_q[7:0], arp_rdata_in};
      end else if (cap_idx <= 5'd13) begin
        sha_d = {sha_q[39:0], arp_rdata_in};
      end else if (cap_idx <= 5'd17) begin
        spa_d = {spa_q[23:0], arp_rdata_in};
      end else if ((cap_idx >= 5'd24) && (cap_idx <= LAST_IDX)) begin
        tpa_d = {tpa_q[23:0], arp_rdata_in};
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    info_d   = info_q;
    ok_inc   = 1'b0;
    drop_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          if (arp_rlast_in) begin
            drop_inc = 1'b1;
          end else begin
            state_d = RECV;
            cnt_d   = 5'd1;
          end
        end
      end
      RECV: begin
        if (hs) begin
          cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 5'd1;
          if (cnt_q == LAST_IDX) begin
            state_d = arp_rlast_in ? CHECK : DRAIN;
          end else if (arp_rlast_in) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      DRAIN: begin
        if (hs && arp_rlast_in) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (pass) begin
          info_d.oper = oper_q;
          info_d.smac = sha_q;
          info_d.sip  = spa_q;
          ok_inc      = 1'b1;
          state_d     = OUT;
        end else begin
          drop_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      OUT: begin
        if (arp_info_ready_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      htype_q <= '0;
      ptype_q <= '0;
      hlen_q  <= '0;
      plen_q  <= '0;
      oper_q  <= '0;
      sha_q   <= '0;
      spa_q   <= '0;
      tpa_q   <= '0;
      info_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      htype_q <= htype_d;
      ptype_q <= ptype_d;
      hlen_q  <= hlen_d;
      plen_q  <= plen_d;
      oper_q  <= oper_d;
      sha_q   <= sha_d;
      spa_q   <= spa_d;
      tpa_q   <= tpa_d;
      info_q  <= info_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_ok_cnt (
    .clk   (logic_clk),
    .rst_n (logic_rst_n),
    .inc   (ok_inc),
    .clear (1'b0),
    .cnt   (arp_ok_cnt_out)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk   (logic_clk),
    .rst_n (logic_rst_n),
    .inc   (drop_inc),
    .clear (1'b0),
    .cnt   (arp_drop_cnt_out)
  );

  assign arp_rready_out     = rready;
  assign arp_info_valid_out = (state_q == OUT);
  assign arp_info_oper_out  = info_q.oper;
  assign arp_info_smac_out  = info_q.smac;
  assign arp_info_sip_out   = info_q.sip;

endmodule

// File: tb/tb_arp_rx_parse.sv
// Directed bench for arp_rx_parse: valid, padded, rejected, runt,
// backpressured and reset-interrupted ARP frames.
module tb_arp_rx_parse;

  logic        logic_clk;
  logic        logic_rst_n;
  logic [7:0]  arp_rdata_in;
  logic        arp_rvalid_in;
  logic        arp_rready_out;
  logic        arp_rlast_in;
  logic        arp_info_valid_out;
  logic        arp_info_ready_in;
  logic [15:0] arp_info_oper_out;
  logic [47:0] arp_info_smac_out;
  logic [31:0] arp_info_sip_out;
  logic [15:0] arp_ok_cnt_out;
  logic [15:0] arp_drop_cnt_out;

  int checks;
  int failures;
  logic [7:0] fr[$];

  localparam logic [47:0] SHA_A = 48'h001122334455;
  localparam logic [47:0] SHA_B = 48'hA0B1C2D3E4F5;
  localparam logic [31:0] SPA_A = 32'hC0A80001;
  localparam logic [31:0] MY_IP = 32'hC0A8006E;

  arp_rx_parse dut (
    .logic_clk          (logic_clk),
    .logic_rst_n        (logic_rst_n),
    .arp_rdata_in       (arp_rdata_in),
    .arp_rvalid_in      (arp_rvalid_in),
    .arp_rready_out     (arp_rready_out),
    .arp_rlast_in       (arp_rlast_in),
    .arp_info_valid_out (arp_info_valid_out),
    .arp_info_ready_in  (arp_info_ready_in),
    .arp_info_oper_out  (arp_info_oper_out),
    .arp_info_smac_out  (arp_info_smac_out),
    .arp_info_sip_out   (arp_info_sip_out),
    .arp_ok_cnt_out     (arp_ok_cnt_out),
    .arp_drop_cnt_out   (arp_drop_cnt_out)
  );

  initial logic_clk = 1'b0;
  always #5 logic_clk = ~logic_clk;

  task automatic build_frame(input logic [15:0] oper, input logic [15:0] ptype,
                             input logic [47:0] sha, input logic [31:0] tpa,
                             input int total_len);
    fr.delete();
    fr.push_back(8'h00); fr.push_back(8'h01);
    fr.push_back(ptype[15:8]); fr.push_back(ptype[7:0]);
    fr.push_back(8'h06); fr.push_back(8'h04);
    fr.push_back(oper[15:8]); fr.push_back(oper[7:0]);
    for (int i = 5; i >= 0; i--) fr.push_back(sha[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) fr.push_back(SPA_A[i*8 +: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(8'h00);
    for (int i = 3; i >= 0; i--) fr.push_back(tpa[i*8 +: 8]);
    while (fr.size() < total_len) fr.push_back(8'h00);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int guard;
    guard = 0;
    arp_rdata_in  = b;
    arp_rvalid_in = 1'b1;
    arp_rlast_in  = last;
    while (!arp_rready_out && guard < 50) begin
      @(negedge logic_clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_byte_timeout: rready=%0b required 1 within 50 cycles", arp_rready_out);
    end
    @(posedge logic_clk);
    @(negedge logic_clk);
    arp_rvalid_in = 1'b0;
    arp_rlast_in  = 1'b0;
  endtask

  task automatic send_range(input int first, input int stop, input logic mark_last);
    for (int i = first; i <= stop; i++) send_byte(fr[i], mark_last && (i == stop));
  endtask

  task automatic expect_record(input string name, input logic [47:0] sha, input int ok_exp);
    checks++;
    if (arp_info_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL %s_check_cycle_valid: got %0b want 0", name, arp_info_valid_out);
    end
    @(negedge logic_clk);
    checks++;
    if (arp_info_valid_out !== 1'b1) begin
      failures++;
      $display("FAIL %s_valid: got %0b want 1", name, arp_info_valid_out);
    end
    checks++;
    if (arp_info_oper_out !== 16'd1) begin
      failures++;
      $display("FAIL %s_oper: got %0h want 1", name, arp_info_oper_out);
    end
    checks++;
    if (arp_info_smac_out !== sha) begin
      failures++;
      $display("FAIL %s_smac: got %h want %h", name, arp_info_smac_out, sha);
    end
    checks++;
    if (arp_info_sip_out !== SPA_A) begin
      failures++;
      $display("FAIL %s_sip: got %h want %h", name, arp_info_sip_out, SPA_A);
    end
    checks++;
    if (arp_ok_cnt_out !== 16'(ok_exp)) begin
      failures++;
      $display("FAIL %s_ok_cnt: got %0d want %0d", name, arp_ok_cnt_out, ok_exp);
    end
  endtask

  task automatic expect_drop(input string name, input int drop_exp);
    @(negedge logic_clk);
    checks++;
    if (arp_info_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL %s_valid: got %0b want 0", name, arp_info_valid_out);
    end
    checks++;
    if (arp_drop_cnt_out !== 16'(drop_exp)) begin
      failures++;
      $display("FAIL %s_drop_cnt: got %0d want %0d", name, arp_drop_cnt_out, drop_exp);
    end
  endtask

  task automatic test_reset();
    logic_rst_n       = 1'b0;
    arp_rdata_in      = 8'h00;
    arp_rvalid_in     = 1'b0;
    arp_rlast_in      = 1'b0;
    arp_info_ready_in = 1'b1;
    repeat (2) @(negedge logic_clk);
    checks++;
    if ({arp_info_valid_out, arp_info_oper_out, arp_info_smac_out, arp_info_sip_out} !== '0) begin
      failures++;
      $display("FAIL reset_record: got v=%0b oper=%h smac=%h sip=%h want all 0",
               arp_info_valid_out, arp_info_oper_out, arp_info_smac_out, arp_info_sip_out);
    end
    checks++;
    if (arp_ok_cnt_out !== 16'd0 || arp_drop_cnt_out !== 16'd0) begin
      failures++;
      $display("FAIL reset_counters: got ok=%0d drop=%0d want 0 0", arp_ok_cnt_out, arp_drop_cnt_out);
    end
    logic_rst_n = 1'b1;
    @(negedge logic_clk);
  endtask

  task automatic test_request();
    build_frame(16'd1, 16'h0800, SHA_A, MY_IP, 28);
    send_range(0, 27, 1'b1);
    expect_record("req28", SHA_A, 1);
    @(negedge logic_clk);
    checks++;
    if (arp_info_valid_out !== 1'b0 || arp_rready_out !== 1'b1) begin
      failures++;
      $display("FAIL req28_release: got valid=%0b rready=%0b want 0 1", arp_info_valid_out, arp_rready_out);
    end
  endtask

  task automatic test_padded();
    build_frame(16'd1, 16'h0800, SHA_A, MY_IP, 46);
    send_range(0, 45, 1'b1);
    expect_record("req46", SHA_A, 2);
    @(negedge logic_clk);
  endtask

  task automatic test_drops();
    build_frame(16'd1, 16'h0800, SHA_A, 32'hC0A8006F, 28);
    send_range(0, 27, 1'b1);
    expect_drop("bad_tpa", 1);
    build_frame(16'd3, 16'h0800, SHA_A, MY_IP, 28);
    send_range(0, 27, 1'b1);
    expect_drop("bad_oper", 2);
    build_frame(16'd1, 16'h86DD, SHA_A, MY_IP, 28);
    send_range(0, 27, 1'b1);
    expect_drop("bad_ptype", 3);
    checks++;
    if (arp_ok_cnt_out !== 16'd2) begin
      failures++;
      $display("FAIL drops_ok_cnt: got %0d want 2", arp_ok_cnt_out);
    end
  endtask

  task automatic test_runt();
    build_frame(16'd1, 16'h0800, SHA_A, MY_IP, 28);
    send_range(0, 19, 1'b1);
    checks++;
    if (arp_drop_cnt_out !== 16'd4 || arp_rready_out !== 1'b1) begin
      failures++;
      $display("FAIL runt: got drop=%0d rready=%0b want 4 1", arp_drop_cnt_out, arp_rready_out);
    end
    send_range(0, 27, 1'b1);
    expect_record("after_runt", SHA_A, 3);
    @(negedge logic_clk);
  endtask

  task automatic test_back_to_back();
    arp_info_ready_in = 1'b0;
    build_frame(16'd1, 16'h0800, SHA_A, MY_IP, 28);
    send_range(0, 27, 1'b1);
    expect_record("bp_first", SHA_A, 4);
    build_frame(16'd1, 16'h0800, SHA_B, MY_IP, 28);
    arp_rdata_in  = fr[0];
    arp_rvalid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge logic_clk);
      checks++;
      if (arp_rready_out !== 1'b0 || arp_info_valid_out !== 1'b1 || arp_info_smac_out !== SHA_A) begin
        failures++;
        $display("FAIL bp_hold_%0d: got rready=%0b valid=%0b smac=%h want 0 1 %h",
                 i, arp_rready_out, arp_info_valid_out, arp_info_smac_out, SHA_A);
      end
    end
    arp_info_ready_in = 1'b1;
    @(negedge logic_clk);
    checks++;
    if (arp_info_valid_out !== 1'b0 || arp_rready_out !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got valid=%0b rready=%0b want 0 1", arp_info_valid_out, arp_rready_out);
    end
    send_range(0, 27, 1'b1);
    expect_record("bp_second", SHA_B, 5);
    @(negedge logic_clk);
  endtask

  task automatic test_reset_midframe();
    build_frame(16'd1, 16'h0800, SHA_A, MY_IP, 28);
    send_range(0, 12, 1'b0);
    logic_rst_n = 1'b0;
    #2;
    checks++;
    if (arp_ok_cnt_out !== 16'd0 || arp_drop_cnt_out !== 16'd0 || arp_info_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL midreset_clear: got ok=%0d drop=%0d valid=%0b want 0 0 0",
               arp_ok_cnt_out, arp_drop_cnt_out, arp_info_valid_out);
    end
    checks++;
    if (arp_info_smac_out !== 48'h0) begin
      failures++;
      $display("FAIL midreset_smac: got %h want 0", arp_info_smac_out);
    end
    logic_rst_n = 1'b1;
    @(negedge logic_clk);
    send_range(13, 27, 1'b1);
    expect_drop("midreset_tail", 1);
    checks++;
    if (arp_ok_cnt_out !== 16'd0) begin
      failures++;
      $display("FAIL midreset_tail_ok: got %0d want 0", arp_ok_cnt_out);
    end
    send_range(0, 27, 1'b1);
    expect_record("midreset_next", SHA_A, 1);
    @(negedge logic_clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_request();
    test_padded();
    test_drops();
    test_runt();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arp_rx_parse.md
Name: arp_rx_parse

Overview:
- Consumes the ARP payload byte stream produced by the ethernet frame splitter (ARP body starting at the hardware-type field; Ethernet header already stripped).
- Parses the 28-byte ARP body and validates the fixed fields and the target IP.
- Presents one parsed request/reply record per accepted frame on a valid/ready interface to the ARP responder and the ARP cache.
- Discards link-layer padding and counts accepted and dropped frames.

Parameters:
- LOCAL_IP, 32'hC0A8_006E, IPv4 address compared against the ARP target protocol address (TPA).
- CNT_WIDTH, 16, width of the two statistics counters.

Ports:
- logic_clk  in  1  system clock.
- logic_rst_n  in  1  asynchronous active-low reset.
- arp_rdata_in  in  8  ARP payload byte.
- arp_rvalid_in  in  1  byte valid.
- arp_rready_out  out  1  byte accepted when valid&ready.
- arp_rlast_in  in  1  last byte of frame (includes padding).
- arp_info_valid_out  out  1  parsed record valid.
- arp_info_ready_in  in  1  consumer accepts record.
- arp_info_oper_out  out  16  opcode (1 request, 2 reply).
- arp_info_smac_out  out  48  sender hardware address.
- arp_info_sip_out  out  32  sender protocol address.
- arp_ok_cnt_out  out  CNT_WIDTH  frames that produced a record, saturating.
- arp_drop_cnt_out  out  CNT_WIDTH  frames rejected, saturating.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - All outputs reset to 0, counters to 0, state to IDLE.
  - Reset mid-frame aborts the frame with no record and no counter change; the remaining bytes of that frame are parsed as a new frame, which fails validation and is counted as a drop.
- Byte offsets within the frame:
  - HTYPE 0-1, PTYPE 2-3, HLEN 4, PLEN 5, OPER 6-7.
  - SHA 8-13, SPA 14-17, THA 18-23, TPA 24-27.
  - All multi-byte fields are big-endian: first byte is the MSB.
- Byte counter: 5 bits, increments on each handshake in RECV and saturates at 28.
- States:
  - IDLE:
    - arp_rready_out=1.
    - First handshake stores byte 0 and goes to RECV with cnt=1.
    - If that byte also carries last, the frame is a runt: drop_cnt++ and stay in IDLE.
  - RECV:
    - arp_rready_out=1; each handshake captures its field.
    - last with cnt<27 (frame shorter than 28 bytes) -> drop_cnt++, go to IDLE.
    - Handshake at cnt=27 without last -> DRAIN; with last -> CHECK.
  - DRAIN:
    - arp_rready_out=1; padding bytes are discarded.
    - Handshake with last -> CHECK.
  - CHECK (one cycle): arp_rready_out=0.
    - Pass condition: HTYPE==1, PTYPE==16'h0800, HLEN==6, PLEN==4, OPER in {1,2}, TPA==LOCAL_IP.
    - Pass -> load the record registers, ok_cnt++, go to OUT.
    - Fail -> drop_cnt++, go to IDLE.
  - OUT:
    - arp_rready_out=0; arp_info_valid_out=1.
    - Record fields stay stable until arp_info_ready_in=1.
    - On ready: valid drops next cycle, go to IDLE.
- Latency: last-byte handshake at cycle N -> CHECK at N+1 -> arp_info_valid_out=1 at N+2. With ready held high, the next frame can be accepted at N+3.
- Backpressure: upstream stalls (rready=0) for the CHECK cycle and for all of OUT. No bytes are lost or reordered.
- A byte with arp_rvalid_in=0 is ignored in every state: no count, no capture.
- Counters saturate at all-ones and never wrap. In CHECK only one counter increments per frame.
- arp_info_* registers change only on entry to OUT, never while valid is high.

Decomposition:
- Shared package eth_pkg:
  - ARP_HTYPE_ETH=16'h0001, IP_TYPE=16'h0800 (shared with the frame splitter), ARP_HLEN=8'd6, ARP_PLEN=8'd4.
  - ARP_OPER_REQ=16'd1, ARP_OPER_REP=16'd2, ARP_BODY_LENGTH=8'd28.
  - typedef enum state_arp_rx {IDLE, RECV, DRAIN, CHECK, OUT}.
  - typedef struct arp_info_t {oper, smac, sip}.
- One natural sub-module: sat_counter (parameter WIDTH, inc, clear), instantiated twice for the statistics counters.

Test Plan:
- Request for 192.168.0.110 from SHA 00:11:22:33:44:55, SPA 192.168.0.1, exactly 28 bytes with last on byte 27, ready high -> valid=1 two cycles after the last byte; oper=1, smac=48'h001122334455, sip=32'hC0A80001; ok_cnt=1.
- Same request padded to 46 bytes (last on byte 45) -> all 46 bytes accepted; one record identical to the previous case; valid asserts 2 cycles after byte 45.
- TPA=192.168.0.111 -> no record; drop_cnt=1. Also OPER=3 and PTYPE=16'h86DD -> each dropped, drop_cnt=3 total.
- Runt of 20 bytes with last on byte 19 -> returns to IDLE; drop_cnt++. The following valid 28-byte frame is parsed correctly.
- Record pending with arp_info_ready_in=0 for 10 cycles while the next frame is valid upstream -> arp_rready_out=0 throughout and the record is stable. Raising ready ends valid and the next frame is accepted intact.
- logic_rst_n pulsed low at byte 12 of a valid request -> outputs and counters cleared immediately; no record. Bytes 13-27 are parsed as a new frame, fail validation and give drop_cnt=1. The next complete request yields ok_cnt=1.
